timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_if.sv | 15 +
 rtl/timer_ctrl.sv | 138 +++++++++++++
 tb/tb_timer_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_if.sv
// Register bus between a bus master and the timer controller.
// The master raises stb with we/addr/wdata; the slave answers with a one-cycle ack.
interface timer_ctrl_if;
   logic        stb;
   logic        we;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;

   modport master (output stb, output we, output addr, output wdata,
                   input ack, input rdata);
   modport slave  (input stb, input we, input addr, input wdata,
                   output ack, output rdata);
endinterface

// File: rtl/timer_ctrl.sv
// Timer controller: configuration and match registers for two timer channels.
// Match values are double-buffered so that a new value only becomes active
// when the channel is idle or when its current match has just fired.
module timer_ctrl #(
   parameter int TIMER_BITS = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   timer_ctrl_if.slave             bus,
   input  logic [1:0]              int_match_in,
   output logic [1:0]              ch_reset,
   output logic [5:0]              clk_source,
   output logic [3:0]              timer_mode,
   output logic [3:0]              output_mode,
   output logic [2*TIMER_BITS-1:0] match,
   output logic                    irq
);

   localparam logic [2:0] ADDR_IE     = 3'd4;
   localparam logic [2:0] ADDR_IP     = 3'd5;
   localparam logic [2:0] ADDR_STATUS = 3'd6;

   logic                  ack_q;
   logic [31:0]           rdata_q;
   logic [7:0]            cfg_q     [2];
   logic [TIMER_BITS-1:0] shadow_q  [2];
   logic [TIMER_BITS-1:0] active_q  [2];
   logic [1:0]            pending_q;
   logic [1:0]            ie_q;
   logic [1:0]            ip_q;
   logic [1:0]            int_sync_q;
   logic [1:0]            int_prev_q;

   logic                  accept;
   logic                  wr;
   logic [1:0]            rise;
   logic [1:0]            ip_clear;
   logic [31:0]           rd_value;

   // A new request is only taken while no ack is outstanding, so a held
   // strobe produces one transfer every other cycle.
   assign accept = bus.stb & ~ack_q;
   assign wr     = accept & bus.we;

   // Rising edges are seen one cycle after the input is sampled; a level
   // held high produces a single pulse.
   assign rise = int_sync_q & ~int_prev_q;

   assign ip_clear = (wr && bus.addr == ADDR_IP) ? bus.wdata[1:0] : 2'b00;

   // Read mux, sampled in the accept cycle and returned during ack.
   always_comb begin
      rd_value = '0;
      case (bus.addr)
         3'd0:        rd_value = {24'b0, cfg_q[0]};
         3'd1:        rd_value = 32'(shadow_q[0]);
         3'd2:        rd_value = {24'b0, cfg_q[1]};
         3'd3:        rd_value = 32'(shadow_q[1]);
         ADDR_IE:     rd_value = {30'b0, ie_q};
         ADDR_IP:     rd_value = {30'b0, ip_q};
         ADDR_STATUS: rd_value = {30'b0, pending_q};
         default:     rd_value = '0;
      endcase
   end

   // Bus handshake: ack one cycle after accept, rdata zero outside ack.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q   <= accept;
         rdata_q <= accept ? rd_value : '0;
      end
   end

   // Per-channel config, shadow and active match; a MATCH write beats a
   // same-cycle shadow-to-active transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int n = 0; n < 2; n++) begin
            cfg_q[n]    <= '0;
            shadow_q[n] <= '0;
            active_q[n] <= '0;
         end
         pending_q <= '0;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (wr && bus.addr == 3'(2 * n))
               cfg_q[n] <= bus.wdata[7:0];
            if (wr && bus.addr == 3'(2 * n + 1)) begin
               shadow_q[n]  <= bus.wdata[TIMER_BITS-1:0];
               pending_q[n] <= 1'b1;
            end else if (pending_q[n] && (!cfg_q[n][0] || rise[n])) begin
               active_q[n]  <= shadow_q[n];
               pending_q[n] <= 1'b0;
            end
         end
      end
   end

   // Interrupt enable and write-1-to-clear pending bits; a new edge wins
   // over a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ie_q <= '0;
         ip_q <= '0;
      end else begin
         if (wr && bus.addr == ADDR_IE)
            ie_q <= bus.wdata[1:0];
         ip_q <= (ip_q & ~ip_clear) | rise;
      end
   end

   // Sample the channel match inputs and keep the previous sample for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         int_sync_q <= '0;
         int_prev_q <= '0;
      end else begin
         int_sync_q <= int_match_in;
         int_prev_q <= int_sync_q;
      end
   end

   assign bus.ack   = ack_q;
   assign bus.rdata = rdata_q;
   assign irq       = |(ip_q & ie_q);

   for (genvar i = 0; i < 2; i++) begin : g_ch
      assign ch_reset[i]                          = ~cfg_q[i][0];
      assign clk_source[3*i+2:3*i]                = cfg_q[i][3:1];
      assign timer_mode[2*i+1:2*i]                = cfg_q[i][5:4];
      assign output_mode[2*i+1:2*i]               = cfg_q[i][7:6];
      assign match[TIMER_BITS*i +: TIMER_BITS]    = active_q[i];
   end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl.
module tb_timer_ctrl;

   logic        clk;
   logic        reset_n;
   logic [1:0]  int_match_in;
   logic [1:0]  ch_reset;
   logic [5:0]  clk_source;
   logic [3:0]  timer_mode;
   logic [3:0]  output_mode;
   logic [31:0] match;
   logic        irq;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] rd;
   logic        irq_ack;
   int          ack_count;

   timer_ctrl_if bus ();

   timer_ctrl #(.TIMER_BITS(16)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus          (bus),
      .int_match_in (int_match_in),
      .ch_reset     (ch_reset),
      .clk_source   (clk_source),
      .timer_mode   (timer_mode),
      .output_mode  (output_mode),
      .match        (match),
      .irq          (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One full transfer; returns the read data and irq seen during the ack cycle.
   task automatic apply_stimulus(input logic w, input logic [2:0] a, input logic [31:0] d,
                                 output logic [31:0] rdata_out, output logic irq_out);
      bus.stb   = 1'b1;
      bus.we    = w;
      bus.addr  = a;
      bus.wdata = d;
      @(posedge clk); #1;
      check_output("ack_high", 64'(bus.ack), 64'd1);
      rdata_out = bus.rdata;
      irq_out   = irq;
      bus.stb   = 1'b0;
      bus.we    = 1'b0;
      @(posedge clk); #1;
      check_output("ack_low", 64'(bus.ack), 64'd0);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      logic [31:0] r;
      logic        q;
      apply_stimulus(1'b1, a, d, r, q);
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] r);
      logic q;
      apply_stimulus(1'b0, a, 32'h0, r, q);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n      = 1'b0;
      int_match_in = 2'b00;
      bus.stb      = 1'b0;
      bus.we       = 1'b0;
      bus.addr     = 3'd0;
      bus.wdata    = 32'h0;

      // Reset state
      cycles(2);
      check_output("rst_ack", 64'(bus.ack), 64'd0);
      check_output("rst_rdata", 64'(bus.rdata), 64'd0);
      check_output("rst_irq", 64'(irq), 64'd0);
      check_output("rst_ch_reset", 64'(ch_reset), 64'd3);
      check_output("rst_cfg", 64'({clk_source, timer_mode, output_mode}), 64'd0);
      check_output("rst_match", 64'(match), 64'd0);
      reset_n = 1'b1;
      cycles(1);

      // Disabled channel: shadow goes straight to active
      bus_write(3'd1, 32'h0000_1234);
      check_output("m0_direct", 64'(match[15:0]), 64'h1234);
      bus_read(3'd6, rd);
      check_output("status_clr", 64'(rd), 64'd0);
      bus_read(3'd1, rd);
      check_output("m0_shadow_rd", 64'(rd), 64'h1234);

      // Enabled channel: transfer waits for int_match rise
      bus_write(3'd0, 32'h0000_0001);
      check_output("ch0_enabled", 64'(ch_reset), 64'd2);
      bus_write(3'd1, 32'h0000_00FF);
      bus_read(3'd6, rd);
      check_output("status_pend", 64'(rd), 64'd1);
      check_output("m0_held", 64'(match[15:0]), 64'h1234);
      int_match_in[0] = 1'b1;
      cycles(1);
      check_output("m0_one_after", 64'(match[15:0]), 64'h1234);
      cycles(1);
      check_output("m0_two_after", 64'(match[15:0]), 64'h00FF);
      bus_read(3'd6, rd);
      check_output("status_done", 64'(rd), 64'd0);
      check_output("irq_ie_off", 64'(irq), 64'd0);
      bus_read(3'd5, rd);
      check_output("ip_no_ie", 64'(rd), 64'd1);
      int_match_in[0] = 1'b0;
      cycles(2);
      bus_write(3'd5, 32'h1);
      bus_read(3'd5, rd);
      check_output("ip_w1c", 64'(rd), 64'd0);

      // Interrupt enable and pending
      bus_write(3'd4, 32'hFFFF_FFFF);
      bus_read(3'd4, rd);
      check_output("ie_width", 64'(rd), 64'd3);
      bus_write(3'd4, 32'h1);
      int_match_in[0] = 1'b1;
      cycles(5);
      int_match_in[0] = 1'b0;
      cycles(2);
      check_output("irq_set", 64'(irq), 64'd1);
      bus_read(3'd5, rd);
      check_output("ip_once", 64'(rd), 64'd1);
      bus_write(3'd5, 32'h0);
      bus_read(3'd5, rd);
      check_output("ip_w0_noop", 64'(rd), 64'd1);
      apply_stimulus(1'b1, 3'd5, 32'h1, rd, irq_ack);
      check_output("irq_ack_cycle", 64'(irq_ack), 64'd0);
      bus_read(3'd5, rd);
      check_output("ip_cleared", 64'(rd), 64'd0);
      // rise detected in the same cycle the clear is accepted
      int_match_in[0] = 1'b1;
      cycles(1);
      bus_write(3'd5, 32'h1);
      bus_read(3'd5, rd);
      check_output("ip_set_wins", 64'(rd), 64'd1);
      check_output("irq_set_wins", 64'(irq), 64'd1);
      int_match_in[0] = 1'b0;
      cycles(2);
      bus_write(3'd5, 32'h3);
      // channel 1 pends regardless of IE, irq stays low
      int_match_in[1] = 1'b1;
      cycles(3);
      int_match_in[1] = 1'b0;
      cycles(2);
      bus_read(3'd5, rd);
      check_output("ip_ch1", 64'(rd), 64'd2);
      check_output("irq_masked", 64'(irq), 64'd0);
      bus_write(3'd5, 32'h3);

      // Held strobe: one transfer every 2 cycles
      ack_count = 0;
      bus.stb  = 1'b1;
      bus.we   = 1'b0;
      bus.addr = 3'd6;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (bus.ack) ack_count++;
         else check_output("rdata_idle", 64'(bus.rdata), 64'd0);
      end
      bus.stb = 1'b0;
      check_output("ack_pulses", 64'(ack_count), 64'd3);
      cycles(1);

      // Config fields, ignored writes, unmapped address
      bus_write(3'd2, 32'h0000_00B5);
      check_output("cs1", 64'(clk_source[5:3]), 64'd2);
      check_output("tm1", 64'(timer_mode[3:2]), 64'd3);
      check_output("om1", 64'(output_mode[3:2]), 64'd2);
      check_output("ch_reset_both", 64'(ch_reset), 64'd0);
      bus_write(3'd0, 32'hFFFF_FFFF);
      bus_read(3'd0, rd);
      check_output("cfg0_width", 64'(rd), 64'hFF);
      check_output("cs0", 64'(clk_source[2:0]), 64'd7);
      bus_write(3'd6, 32'hFFFF_FFFF);
      bus_read(3'd6, rd);
      check_output("status_ro", 64'(rd), 64'd0);
      bus_write(3'd7, 32'hFFFF_FFFF);
      bus_read(3'd7, rd);
      check_output("addr7", 64'(rd), 64'd0);

      // MATCH1 write beats a same-cycle transfer
      bus_write(3'd3, 32'h0000_ABCD);
      check_output("m1_held", 64'(match[31:16]), 64'h0);
      int_match_in[1] = 1'b1;
      cycles(1);
      bus_write(3'd3, 32'h0000_5555);
      check_output("m1_prio", 64'(match[31:16]), 64'h0);
      bus_read(3'd6, rd);
      check_output("status_prio", 64'(rd), 64'd2);
      bus_read(3'd3, rd);
      check_output("m1_shadow", 64'(rd), 64'h5555);
      int_match_in[1] = 1'b0;
      cycles(3);
      int_match_in[1] = 1'b1;
      cycles(3);
      check_output("m1_active", 64'(match[31:16]), 64'h5555);
      int_match_in[1] = 1'b0;
      bus_write(3'd5, 32'h3);

      // Asynchronous reset in the middle of a transfer
      int_match_in[0] = 1'b1;
      cycles(3);
      int_match_in[0] = 1'b0;
      check_output("irq_pre_rst", 64'(irq), 64'd1);
      bus.stb  = 1'b1;
      bus.we   = 1'b0;
      bus.addr = 3'd2;
      @(posedge clk); #1;
      check_output("ack_pre_rst", 64'(bus.ack), 64'd1);
      #2;
      reset_n = 1'b0;
      bus.stb = 1'b0;
      #1;
      check_output("arst_ack", 64'(bus.ack), 64'd0);
      check_output("arst_rdata", 64'(bus.rdata), 64'd0);
      check_output("arst_irq", 64'(irq), 64'd0);
      check_output("arst_ch_reset", 64'(ch_reset), 64'd3);
      check_output("arst_cfg", 64'({clk_source, timer_mode, output_mode}), 64'd0);
      check_output("arst_match", 64'(match), 64'd0);
      #3;
      reset_n = 1'b1;
      @(posedge clk); #1;
      check_output("no_stale_ack", 64'(bus.ack), 64'd0);
      bus_read(3'd2, rd);
      check_output("cfg1_after_rst", 64'(rd), 64'd0);
      // first edge after release accepts a waiting request
      reset_n = 1'b0;
      #2;
      bus.stb  = 1'b1;
      bus.we   = 1'b0;
      bus.addr = 3'd4;
      reset_n  = 1'b1;
      @(posedge clk); #1;
      check_output("first_edge_ack", 64'(bus.ack), 64'd1);
      check_output("ie_after_rst", 64'(bus.rdata), 64'd0);
      bus.stb = 1'b0;
      cycles(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
